// File: rtl/shift_engine.sv
// Multi-mode shift engine: HOLD/LOAD/LEFT/RIGHT/ASR (+ROL/ROR when SHIFT_ENGINE_ROTATE_EN is defined), one bit per clock.
// Latency: an N-step shift takes N edges (the first on the accept edge); LOAD/HOLD take 1 edge; done pulses the cycle after the last edge.
// Backpressure: cmd_ready = !busy; commands presented while busy are ignored and must be held upstream.
module shift_engine #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       mode_i,
    input  logic [CNT_W-1:0] amount_i,
    input  logic [WIDTH-1:0] par_i,
    input  logic             D,
    output logic [WIDTH-1:0] P,
    output logic             ser_o,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_LEFT = 3'b010;
    localparam logic [2:0] MODE_RGHT = 3'b011;
    localparam logic [2:0] MODE_ASR  = 3'b100;
`ifdef SHIFT_ENGINE_ROTATE_EN
    localparam logic [2:0] MODE_ROL  = 3'b110;
    localparam logic [2:0] MODE_ROR  = 3'b111;
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] eff_amt;
    logic [2:0]       cur_mode;
    logic             cur_is_shift;
    logic [WIDTH-1:0] step_p;
    logic             step_ser;
    logic             accept;

    // busy comes straight from the state register, so cmd_ready never depends on cmd_valid
    assign busy      = (state == S_SHIFT);
    assign cmd_ready = ~busy;
    assign accept    = cmd_valid & cmd_ready;

    // amounts beyond the register width saturate at WIDTH
    assign eff_amt  = (amount_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount_i;

    // the accept edge steps with the live mode; later edges use the captured mode
    assign cur_mode = busy ? mode_q : mode_i;

    // next register value and shifted-out bit for one step of the current mode
    always_comb begin
        step_p       = P;
        step_ser     = ser_o;
        cur_is_shift = 1'b1;
        case (cur_mode)
            MODE_LEFT: begin
                step_p   = {P[WIDTH-2:0], D};
                step_ser = P[WIDTH-1];
            end
            MODE_RGHT: begin
                step_p   = {D, P[WIDTH-1:1]};
                step_ser = P[0];
            end
            MODE_ASR: begin
                step_p   = {P[WIDTH-1], P[WIDTH-1:1]};
                step_ser = P[0];
            end
`ifdef SHIFT_ENGINE_ROTATE_EN
            MODE_ROL: begin
                step_p   = {P[WIDTH-2:0], P[WIDTH-1]};
                step_ser = P[WIDTH-1];
            end
            MODE_ROR: begin
                step_p   = {P[0], P[WIDTH-1:1]};
                step_ser = P[0];
            end
`endif
            default: cur_is_shift = 1'b0;
        endcase
    end

    // command acceptance, step sequencing and the registered done pulse
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_IDLE;
            P         <= '0;
            ser_o     <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            mode_q    <= 3'b000;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode_q <= mode_i;
                        if (mode_i == MODE_LOAD) begin
                            P    <= par_i;
                            done <= 1'b1;
                        end else if (!cur_is_shift || (eff_amt == '0)) begin
                            done <= 1'b1;
                        end else begin
                            P     <= step_p;
                            ser_o <= step_ser;
                            if (eff_amt == CNT_W'(1)) begin
                                done <= 1'b1;
                            end else begin
                                state     <= S_SHIFT;
                                remaining <= eff_amt - CNT_W'(1);
                            end
                        end
                    end
                end
                S_SHIFT: begin
                    P         <= step_p;
                    ser_o     <= step_ser;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine (WIDTH=8): directed scenarios plus random commands against a behavioural model.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Rotate expectations follow SHIFT_ENGINE_ROTATE_EN exactly as the design does.
module tb_shift_engine;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    mode_i;
    logic [CW-1:0] amount_i;
    logic [W-1:0]  par_i;
    logic          D;
    logic [W-1:0]  P;
    logic          ser_o;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int   mp;
    int   ms;

    shift_engine #(.WIDTH(W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .mode_i    (mode_i),
        .amount_i  (amount_i),
        .par_i     (par_i),
        .D         (D),
        .P         (P),
        .ser_o     (ser_o),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_is_shift(input int m);
`ifdef SHIFT_ENGINE_ROTATE_EN
        return (m == 2) || (m == 3) || (m == 4) || (m == 6) || (m == 7);
`else
        return (m == 2) || (m == 3) || (m == 4);
`endif
    endfunction

    // one step expressed as integer arithmetic on an 8-bit value
    task automatic model_step(input int m, input int d);
        case (m)
            2: begin ms = (mp >> 7) & 1; mp = ((mp * 2) + d) % 256; end
            3: begin ms = mp % 2;        mp = (mp / 2) + d * 128; end
            4: begin ms = mp % 2;        mp = (mp / 2) + (mp >= 128 ? 128 : 0); end
            6: begin ms = mp / 128;      mp = ((mp * 2) % 256) + (mp / 128); end
            7: begin ms = mp % 2;        mp = (mp / 2) + (mp % 2) * 128; end
            default: ;
        endcase
    endtask

    function automatic int pick(input int dsel);
        if (dsel == 0) return 0;
        if (dsel == 1) return 1;
        return int'($urandom_range(0, 1));
    endfunction

    // issue one command from an idle engine and check every cycle until its done pulse
    task automatic run_cmd(input int m, input int amt, input int par, input int dsel, input string tag);
        int n;
        int d;
        n = (amt > W) ? W : amt;
        chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
        d         = pick(dsel);
        mode_i    = 3'(m);
        amount_i  = CW'(amt);
        par_i     = W'(par);
        D         = d[0];
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        if (!model_is_shift(m) || n == 0) begin
            if (m == 1) mp = par;
            chk({tag, "_P"},    32'(P),     32'(mp));
            chk({tag, "_ser"},  32'(ser_o), 32'(ms));
            chk({tag, "_busy"}, 32'(busy),  32'd0);
            chk({tag, "_done"}, 32'(done),  32'd1);
        end else begin
            for (int k = 1; k <= n; k++) begin
                model_step(m, d);
                chk({tag, "_P"},   32'(P),     32'(mp));
                chk({tag, "_ser"}, 32'(ser_o), 32'(ms));
                if (k < n) begin
                    chk({tag, "_busy"}, 32'(busy),      32'd1);
                    chk({tag, "_done"}, 32'(done),      32'd0);
                    chk({tag, "_nrdy"}, 32'(cmd_ready), 32'd0);
                    d = pick(dsel);
                    D = d[0];
                    tick();
                end else begin
                    chk({tag, "_busy"}, 32'(busy), 32'd0);
                    chk({tag, "_done"}, 32'(done), 32'd1);
                end
            end
        end
    endtask

    initial begin
        nrst = 1'b0; cmd_valid = 1'b0; mode_i = 3'd0; amount_i = '0; par_i = '0; D = 1'b0;
        mp = 0; ms = 0;
        #3;
        chk("rst_P",    32'(P),         32'h0);
        chk("rst_ser",  32'(ser_o),     32'h0);
        chk("rst_busy", 32'(busy),      32'h0);
        chk("rst_done", 32'(done),      32'h0);
        chk("rst_rdy",  32'(cmd_ready), 32'h1);
        #4 nrst = 1'b1;
        tick();

        // LOAD then LEFT 3 with D=1
        run_cmd(1, 0, 8'hA5, 0, "load_a5");
        tick();
        chk("load_done_single", 32'(done), 32'd0);
        run_cmd(2, 3, 0, 1, "left3");
        chk("left3_final", 32'(P), 32'h2F);
        tick();
        chk("left3_done_single", 32'(done), 32'd0);

        // ASR by 2
        run_cmd(1, 0, 8'h90, 0, "load_90");
        run_cmd(4, 2, 0, 1, "asr2");
        chk("asr2_final", 32'(P), 32'hE4);
        chk("asr2_ser",   32'(ser_o), 32'h0);

        // rotate right by 8 (or HOLD without rotate support)
        run_cmd(1, 0, 8'h3C, 0, "load_3c");
        run_cmd(7, 8, 0, 2, "ror8");
        chk("ror8_restore", 32'(P), 32'h3C);
        run_cmd(6, 5, 0, 2, "rol5");

        // clamp and zero amount
        run_cmd(1, 0, 8'hFF, 0, "load_ff");
        run_cmd(3, 12, 0, 0, "right12");
        chk("right12_final", 32'(P), 32'h00);
        run_cmd(1, 0, 8'h6B, 0, "load_6b");
        run_cmd(2, 0, 0, 1, "left0");
        chk("left0_final", 32'(P), 32'h6B);
        run_cmd(5, 3, 0, 1, "reserved");
        run_cmd(0, 4, 0, 1, "hold");

        // reset mid-shift: RIGHT 6 on 0xFF, reset after 2 steps with no clock edge
        run_cmd(1, 0, 8'hFF, 0, "load_ff2");
        mode_i = 3'd3; amount_i = CW'(6); D = 1'b0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_P_before", 32'(P),    32'h3F);
        chk("mid_busy",     32'(busy), 32'd1);
        #2 nrst = 1'b0;
        #1;
        chk("arst_P",    32'(P),         32'h0);
        chk("arst_busy", 32'(busy),      32'h0);
        chk("arst_done", 32'(done),      32'h0);
        chk("arst_rdy",  32'(cmd_ready), 32'h1);
        chk("arst_ser",  32'(ser_o),     32'h0);
        mp = 0; ms = 0;
        #2 nrst = 1'b1;
        tick();
        chk("arst_stays_idle", 32'(busy), 32'h0);

        // handshake: LOAD held while busy, accepted in the done cycle
        run_cmd(1, 0, 8'h0F, 0, "load_0f");
        tick();
        mode_i = 3'd3; amount_i = CW'(4); D = 1'b0; cmd_valid = 1'b1;
        tick();
        model_step(3, 0);
        mode_i = 3'd1; par_i = 8'h55;
        chk("hs_nrdy", 32'(cmd_ready), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            model_step(3, 0);
            chk("hs_P_shift", 32'(P), 32'(mp));
        end
        chk("hs_done", 32'(done),      32'd1);
        chk("hs_rdy",  32'(cmd_ready), 32'd1);
        chk("hs_P_0",  32'(P),         32'h00);
        tick();
        cmd_valid = 1'b0;
        mp = 8'h55;
        chk("hs_load_P",    32'(P),    32'h55);
        chk("hs_load_done", 32'(done), 32'd1);
        tick();
        chk("hs_done_clear", 32'(done), 32'd0);

        // random back-to-back commands
        for (int i = 0; i < 40; i++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 255)), 2, "rand");
            if ($urandom_range(0, 3) == 0) begin
                tick();
                chk("rand_done_single", 32'(done), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised multi-mode shift engine; the successor to the fixed 8-bit shift register. It accepts one command per valid/ready handshake: hold, load, or a multi-step shift/rotate of 0..WIDTH positions. Each shift command executes one bit per clock, exposes the shifted-out bit serially and reports completion with a one-cycle `done` pulse. It sits between register-file style control and serial I/O (SPI-like framing, bit-serial arithmetic).

## Interface
- `WIDTH`, default 8: register width, ≥2.
- `CNT_W`, localparam = $clog2(WIDTH+1): width of the shift-amount field.

- `clk` in 1: system clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine can accept a command; equals !busy.
- `mode_i` in 3: command mode, see Operation.
- `amount_i` in CNT_W: number of shift steps.
- `par_i` in WIDTH: parallel load data.
- `D` in 1: serial input, sampled live on every step edge.
- `P` out WIDTH: register contents.
- `ser_o` out 1: bit shifted out on the most recent step; holds otherwise.
- `busy` out 1: shift in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- Mode encoding:
  - 000 HOLD
  - 001 LOAD (P←par_i)
  - 010 LEFT ({P[W-2:0],D}, ser_o←P[W-1])
  - 011 RIGHT ({D,P[W-1:1]}, ser_o←P[0])
  - 100 ASR ({P[W-1],P[W-1:1]}, ser_o←P[0], D ignored)
  - 101 reserved, treated as HOLD
  - 110 ROL (ser_o←P[W-1])
  - 111 ROR (ser_o←P[0])
- States:
  - IDLE: cmd_ready=1.
  - SHIFT: busy=1, cmd_ready=0.
- Accept: occurs on an edge where cmd_valid && cmd_ready. mode_i and the effective amount are captured on that edge.
- Effective amount N = min(amount_i, WIDTH).
- HOLD, LOAD, reserved, or any shift mode with N=0: execute on the accept edge (LOAD writes P; the others leave P unchanged). Stay in IDLE. done=1 in the next cycle.
- Shift mode with N≥1: the accept edge performs step 1. If N=1, stay in IDLE. Otherwise enter SHIFT with remaining=N-1, and perform one step per edge until remaining reaches 0, then return to IDLE.
- done is registered and is high exactly one cycle after the final step edge.
- cmd_valid while busy is ignored; upstream must hold the command until cmd_ready.
- A new command may be accepted in the same cycle that done is high (back-to-back).

## Timing
- Reset values (asynchronous, immediate on nrst low, including mid-shift): P=0, ser_o=0, busy=0, done=0, cmd_ready=1, state IDLE, counter 0.
- Latency: an N-step shift takes N edges starting with the accept edge. busy is high for N-1 cycles. done is high in the cycle after edge N.
- LOAD/HOLD latency: 1 edge; done in the following cycle.
- No combinational path from cmd_valid to cmd_ready.
- Rotate by N=WIDTH restores the original P.

## Configuration
- `SHIFT_ENGINE_ROTATE_EN`:
  - Defined: modes 110/111 perform ROL/ROR.
  - Undefined: 110/111 behave exactly as HOLD (P unchanged, done after 1 edge, no busy), and rotate logic is not synthesised.

## Test plan
- Reset mid-shift: start RIGHT N=6 on P=0xFF, drop nrst after 2 steps → P=0x00, busy=0, done=0, cmd_ready=1 immediately, with no clock needed.
- LOAD then LEFT: LOAD 0xA5, then LEFT amount 3 with D=1 → P=0x2F after 3 edges; ser_o sequence 1,0,1; busy high 2 cycles; single done pulse.
- ASR: P=0x90, mode 100, amount 2, D=1 → P=0xE4, ser_o=0, done one cycle after the second edge.
- Rotate with macro: P=0x3C, ROR amount 8 → P=0x3C after 8 edges, busy 7 cycles. Without macro: P=0x3C, done after 1 edge, busy never high.
- Clamp and zero: P=0xFF, RIGHT amount 12, D=0 (WIDTH=8) → clamped to 8, P=0x00. LEFT amount 0 → P unchanged, done next cycle, busy 0.
- Handshake: hold cmd_valid with LOAD 0x55 while busy → no effect until cmd_ready. Accepted in the done cycle, so P=0x55 one edge later.
